// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scanner
// Contents: slot FSM state enum, active-low glyph table (gfedcba), off constants.
package seg_pkg;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_state_e;

    localparam logic [6:0] HEX_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Entry n is the active-low glyph for hex digit n; bit6=g .. bit0=a.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational hex nibble to active-low glyph converter
// Ports: nibble_i (4b value), glyph_o (7b active-low segments, bit0=a .. bit6=g).
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - eight-digit multiplexed seven-segment scanner with tear-free load
// Ports: clk, rst (async active-high), data_i (8 nibbles), en_i (digit mask),
//        load_i (capture strobe), busy_o (load pending), hex (active-low segments),
//        AN (active-low anodes), frame_o (pulse after each frame boundary).
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic [7:0]  en_i,
    input  logic        load_i,
    output logic        busy_o,
    output logic [6:0]  hex,
    output logic [7:0]  AN,
    output logic        frame_o
);

    localparam logic [15:0] CNT_MAX   = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_CNT = 16'(BLANK);

    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    slot_state_e  state_q, state_d;
    logic [31:0]  pend_data_q, pend_data_d;
    logic [7:0]   pend_en_q, pend_en_d;
    logic         busy_q, busy_d;
    logic [31:0]  shadow_data_q, shadow_data_d;
    logic [7:0]   shadow_en_q, shadow_en_d;
    logic         frame_q;
    logic [6:0]   hex_q, hex_d;
    logic [7:0]   an_q, an_d;

    logic         wrap;
    logic         boundary;
    logic [6:0]   glyph_w;

    assign wrap     = (cnt_q == CNT_MAX);
    assign boundary = wrap && (idx_q == 3'd7);

    // Prescaler and digit index; idx wraps 7->0 naturally in 3 bits.
    always_comb begin
        cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
        idx_d = wrap ? idx_q + 3'd1 : idx_q;
    end

    // Slot FSM: state_q is SHOW exactly when cnt_q >= BLANK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_BLANK: if (!wrap && cnt_d == BLANK_CNT) state_d = SLOT_SHOW;
            SLOT_SHOW:  if (wrap)                        state_d = SLOT_BLANK;
            default:                                     state_d = SLOT_BLANK;
        endcase
    end

    // Double buffering: loads land in the pending register and are promoted to
    // the shadow only at the frame boundary, so a frame never mixes two loads.
    // A load arriving on the boundary itself bypasses pending entirely.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_en_d     = pend_en_q;
        busy_d        = busy_q;
        shadow_data_d = shadow_data_q;
        shadow_en_d   = shadow_en_q;
        if (boundary) begin
            if (load_i) begin
                shadow_data_d = data_i;
                shadow_en_d   = en_i;
            end else if (busy_q) begin
                shadow_data_d = pend_data_q;
                shadow_en_d   = pend_en_q;
            end
            busy_d = 1'b0;
        end else if (load_i) begin
            pend_data_d = data_i;
            pend_en_d   = en_i;
            busy_d      = 1'b1;
        end
    end

    seg_decode u_decode (
        .nibble_i (shadow_data_q[{idx_q, 2'b00} +: 4]),
        .glyph_o  (glyph_w)
    );

    always_comb begin
        hex_d = HEX_OFF;
        an_d  = AN_OFF;
        if (state_q == SLOT_SHOW && shadow_en_q[idx_q]) begin
            hex_d = glyph_w;
            an_d  = ~(8'd1 << idx_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= 16'd0;
            idx_q         <= 3'd0;
            state_q       <= SLOT_BLANK;
            pend_data_q   <= 32'd0;
            pend_en_q     <= 8'd0;
            busy_q        <= 1'b0;
            shadow_data_q <= 32'd0;
            shadow_en_q   <= 8'd0;
            frame_q       <= 1'b0;
            hex_q         <= HEX_OFF;
            an_q          <= AN_OFF;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            pend_data_q   <= pend_data_d;
            pend_en_q     <= pend_en_d;
            busy_q        <= busy_d;
            shadow_data_q <= shadow_data_d;
            shadow_en_q   <= shadow_en_d;
            frame_q       <= boundary;
            hex_q         <= hex_d;
            an_q          <= an_d;
        end
    end

    assign busy_o  = busy_q;
    assign frame_o = frame_q;
    assign hex     = hex_q;
    assign AN      = an_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan (scoreboarded reference model)
module tb_seg_scan;

    localparam int P = 8;
    localparam int B = 2;

    typedef struct {
        logic [6:0] hex;
        logic [7:0] an;
        logic       busy;
        logic       frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = '0;
    logic [7:0]  en_i = '0;
    logic        load_i = 1'b0;
    logic        busy_o, frame_o;
    logic [6:0]  hex;
    logic [7:0]  AN;

    logic [31:0] data2_i = '0;
    logic [7:0]  en2_i = '0;
    logic        load2_i = 1'b0;
    logic        busy2_o, frame2_o;
    logic [6:0]  hex2;
    logic [7:0]  an2;

    int n_vec = 0;
    int n_fail = 0;

    logic [6:0] G [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state (state before the next rising edge)
    int          m_cnt, m_idx;
    logic [31:0] m_sh, m_pd;
    logic [7:0]  m_sen, m_pe;
    logic        m_busy;
    exp_t        sb [$];

    always #5 clk = ~clk;

    seg_scan #(.PRESCALE(P), .BLANK(B)) u_dut (
        .clk(clk), .rst(rst), .data_i(data_i), .en_i(en_i), .load_i(load_i),
        .busy_o(busy_o), .hex(hex), .AN(AN), .frame_o(frame_o)
    );

    seg_scan #(.PRESCALE(4), .BLANK(3)) u_small (
        .clk(clk), .rst(rst), .data_i(data2_i), .en_i(en2_i), .load_i(load2_i),
        .busy_o(busy2_o), .hex(hex2), .AN(an2), .frame_o(frame2_o)
    );

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_sh = '0; m_pd = '0; m_sen = '0; m_pe = '0; m_busy = 1'b0;
    endtask

    // One clock: drive at negedge, push the expected post-edge outputs, compare after the edge.
    task automatic tick(input logic ld, input logic [31:0] d, input logic [7:0] e);
        exp_t x;
        logic bnd, show;
        @(negedge clk);
        load_i = ld; data_i = d; en_i = e;
        if (rst) begin
            x.hex = 7'h7F; x.an = 8'hFF; x.busy = 1'b0; x.frame = 1'b0;
            model_reset();
        end else begin
            bnd  = (m_cnt == P - 1) && (m_idx == 7);
            show = (m_cnt >= B) && m_sen[m_idx];
            x.hex   = show ? G[m_sh[m_idx*4 +: 4]] : 7'h7F;
            x.an    = show ? ~(8'd1 << m_idx) : 8'hFF;
            x.frame = bnd;
            if (bnd) begin
                if (ld) begin m_sh = d; m_sen = e; end
                else if (m_busy) begin m_sh = m_pd; m_sen = m_pe; end
                m_busy = 1'b0;
            end else if (ld) begin
                m_pd = d; m_pe = e; m_busy = 1'b1;
            end
            x.busy = m_busy;
            if (m_cnt == P - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        sb.push_back(x);
        @(posedge clk); #1;
        x = sb.pop_front();
        n_vec += 4;
        if (hex !== x.hex)     begin n_fail++; $display("FAIL sb_hex t=%0t got %h exp %h", $time, hex, x.hex); end
        if (AN !== x.an)       begin n_fail++; $display("FAIL sb_an t=%0t got %h exp %h", $time, AN, x.an); end
        if (busy_o !== x.busy) begin n_fail++; $display("FAIL sb_busy t=%0t got %b exp %b", $time, busy_o, x.busy); end
        if (frame_o !== x.frame) begin n_fail++; $display("FAIL sb_frame t=%0t got %b exp %b", $time, frame_o, x.frame); end
        load_i = 1'b0;
    endtask

    task automatic tick_until(input int cnt, input int idx);
        for (int i = 0; i < 2 * P * 8 && !(m_cnt == cnt && m_idx == idx); i++) tick(0, '0, '0);
    endtask

    task automatic wait_frame();
        int guard;
        guard = 0;
        do begin
            tick(0, '0, '0);
            guard++;
        end while (frame_o !== 1'b1 && guard < 200);
        n_vec++;
        if (frame_o !== 1'b1) begin n_fail++; $display("FAIL wait_frame timeout got %b exp 1", frame_o); end
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(0, '0, '0);
        n_vec++;
        if ({hex, AN, busy_o, frame_o} !== {7'h7F, 8'hFF, 2'b00}) begin
            n_fail++; $display("FAIL reset_outputs got %h exp %h", {hex, AN, busy_o, frame_o}, {7'h7F, 8'hFF, 2'b00});
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int frames, lit;
        frames = 0; lit = 0;
        for (int i = 0; i < 3 * 8 * P; i++) begin
            tick(0, '0, '0);
            if (frame_o) frames++;
            if (AN !== 8'hFF || hex !== 7'h7F) lit++;
        end
        n_vec += 2;
        if (frames != 3) begin n_fail++; $display("FAIL idle_frames got %0d exp 3", frames); end
        if (lit != 0)    begin n_fail++; $display("FAIL idle_dark got %0d lit cycles exp 0", lit); end
    endtask

    task automatic test_load_mid();
        int on_cnt [8];
        tick_until(3, 3);
        tick(1, 32'h76543210, 8'hFF);
        n_vec++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL load_busy got %b exp 1", busy_o); end
        wait_frame();
        n_vec++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL load_busy_clr got %b exp 0", busy_o); end
        for (int k = 0; k < 8; k++) on_cnt[k] = 0;
        for (int i = 0; i < 8 * P; i++) begin
            tick(0, '0, '0);
            for (int k = 0; k < 8; k++)
                if (AN === ~(8'd1 << k) && hex === G[k]) on_cnt[k]++;
        end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (on_cnt[k] != P - B) begin n_fail++; $display("FAIL load_digit%0d got %0d exp %0d", k, on_cnt[k], P - B); end
        end
    endtask

    task automatic test_two_loads();
        logic [31:0] v;
        int ones, good;
        v = 32'hFEDCBA98;
        ones = 0; good = 0;
        tick_until(1, 2);
        tick(1, 32'h11111111, 8'hFF);
        tick(0, '0, '0);
        tick(0, '0, '0);
        tick(1, v, 8'hFF);
        wait_frame();
        for (int i = 0; i < 8 * P; i++) begin
            tick(0, '0, '0);
            if (AN !== 8'hFF && hex === G[1]) ones++;
            for (int k = 0; k < 8; k++)
                if (AN === ~(8'd1 << k) && hex === G[v[k*4 +: 4]]) good++;
        end
        n_vec += 2;
        if (ones != 0)             begin n_fail++; $display("FAIL two_loads_stale got %0d exp 0", ones); end
        if (good != 8 * (P - B))   begin n_fail++; $display("FAIL two_loads_shown got %0d exp %0d", good, 8 * (P - B)); end
    endtask

    task automatic test_boundary_load();
        int busy_seen, d0, others;
        busy_seen = 0; d0 = 0; others = 0;
        tick_until(P - 1, 7);
        tick(1, 32'h0000000F, 8'h01);
        if (busy_o !== 1'b0) busy_seen++;
        for (int i = 0; i < 8 * P; i++) begin
            tick(0, '0, '0);
            if (busy_o !== 1'b0) busy_seen++;
            if (AN === 8'hFE && hex === G[15]) d0++;
            if (AN[7:1] !== 7'h7F) others++;
        end
        n_vec += 3;
        if (busy_seen != 0) begin n_fail++; $display("FAIL bnd_busy got %0d exp 0", busy_seen); end
        if (d0 != P - B)    begin n_fail++; $display("FAIL bnd_digit0 got %0d exp %0d", d0, P - B); end
        if (others != 0)    begin n_fail++; $display("FAIL bnd_others got %0d exp 0", others); end
    endtask

    task automatic test_reset_mid();
        int lit;
        lit = 0;
        tick_until(3, 0);
        tick(1, 32'hAAAAAAAA, 8'hFF);
        tick(0, '0, '0);
        n_vec += 2;
        if (AN !== 8'hFE)    begin n_fail++; $display("FAIL rstmid_pre_an got %h exp fe", AN); end
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy got %b exp 1", busy_o); end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if ({hex, AN, busy_o, frame_o} !== {7'h7F, 8'hFF, 2'b00}) begin
            n_fail++; $display("FAIL rstmid_async got %h exp %h", {hex, AN, busy_o, frame_o}, {7'h7F, 8'hFF, 2'b00});
        end
        tick(0, '0, '0);
        tick(0, '0, '0);
        rst = 1'b0;
        for (int i = 0; i < 2 * 8 * P; i++) begin
            tick(0, '0, '0);
            if (AN !== 8'hFF || busy_o !== 1'b0) lit++;
        end
        n_vec++;
        if (lit != 0) begin n_fail++; $display("FAIL rstmid_dark got %0d exp 0", lit); end
    endtask

    task automatic test_small_prescale();
        int q2 [$];
        int e, frames, misaligned;
        logic [31:0] v;
        v = 32'h76543210;
        frames = 0; misaligned = 0;
        rst = 1'b1;
        tick(0, '0, '0);
        rst = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 8; k++) q2.push_back(k);
        for (int i = 1; i <= 96; i++) begin
            if (i == 1) begin load2_i = 1'b1; data2_i = v; en2_i = 8'hFF; end
            tick(0, '0, '0);
            load2_i = 1'b0;
            if (frame2_o) frames++;
            if (an2 !== 8'hFF) begin
                if (i % 4 != 0) misaligned++;
                n_vec++;
                if (q2.size() == 0) begin
                    n_fail++; $display("FAIL small_extra t=%0t got an %h exp ff", $time, an2);
                end else begin
                    e = q2.pop_front();
                    if (an2 !== ~(8'd1 << e) || hex2 !== G[v[e*4 +: 4]]) begin
                        n_fail++; $display("FAIL small_digit got %h/%h exp %h/%h", an2, hex2, ~(8'd1 << e), G[v[e*4 +: 4]]);
                    end
                end
            end
        end
        n_vec += 3;
        if (q2.size() != 0) begin n_fail++; $display("FAIL small_missing got %0d left exp 0", q2.size()); end
        if (frames != 3)    begin n_fail++; $display("FAIL small_frames got %0d exp 3", frames); end
        if (misaligned != 0) begin n_fail++; $display("FAIL small_align got %0d exp 0", misaligned); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_mid();
        test_two_loads();
        test_boundary_load();
        test_reset_mid();
        test_small_prescale();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000: clock cycles per digit slot; legal values 4..65535.
REQ-002 SHALL have parameter BLANK, default 16: anti-ghost cycles at the start of each slot; legal values 1..PRESCALE-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port data_i, input, 32: nibble k (bits 4k+3:4k) drives digit k.
REQ-006 SHALL have port en_i, input, 8: digit enable mask, bit k enables digit k.
REQ-007 SHALL have port load_i, input, 1: single-cycle strobe that captures data_i and en_i.
REQ-008 SHALL have port busy_o, output, 1: high while a captured load is pending and not yet displayed.
REQ-009 SHALL have port hex, output, 7: active-low segments, bit0=a .. bit6=g.
REQ-010 SHALL have port AN, output, 8: active-low anodes, bit k = digit k.
REQ-011 SHALL have port frame_o, output, 1: one-cycle pulse on each frame boundary.

Function
REQ-012 SHALL run a prescaler cnt that counts 0..PRESCALE-1 and wraps to 0.
REQ-013 SHALL advance digit index idx (0..7) on each cnt wrap; idx 7 SHALL wrap to 0; one frame = 8*PRESCALE cycles.
REQ-014 SHALL define the frame boundary as the cycle where cnt=PRESCALE-1 and idx=7.
REQ-015 SHALL run a two-state FSM per slot: BLANK while cnt<BLANK, SHOW while cnt>=BLANK; BLANK->SHOW at cnt=BLANK; SHOW->BLANK on cnt wrap.
REQ-016 In BLANK, SHALL drive AN=8'hFF and hex=7'h7F.
REQ-017 In SHOW, SHALL drive AN with only bit idx low when shadow_en[idx]=1, else AN=8'hFF; SHALL drive hex with the glyph of shadow nibble idx when enabled, else 7'h7F.
REQ-018 SHALL register hex and AN: outputs reflect the cnt/idx state of the previous cycle (1-cycle latency).
REQ-019 SHALL use these active-low gfedcba glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 On load_i=1 in a non-boundary cycle, SHALL copy data_i/en_i into the pending register and set busy_o=1 on the next cycle.
REQ-021 On load_i=1 while busy_o=1, SHALL overwrite the pending register (last load wins).
REQ-022 On the frame boundary, SHALL copy the pending register into the shadow register if busy_o=1, and SHALL clear busy_o.
REQ-023 On load_i=1 in the frame-boundary cycle, SHALL copy data_i/en_i directly into the shadow register and leave busy_o=0.
REQ-024 SHALL never change shadow contents mid-frame (no tearing).
REQ-025 SHALL assert frame_o for exactly the cycle after each frame boundary.

Reset
REQ-026 While rst=1, SHALL hold cnt=0, idx=0, FSM=BLANK, pending=0, shadow data=0, shadow_en=0, busy_o=0, frame_o=0, hex=7'h7F, AN=8'hFF.
REQ-027 Reset asserted mid-frame or with a pending load SHALL discard the pending load; after release, the first slot SHALL start at idx 0, cnt 0.

Structure
REQ-028 Shared package seg_pkg SHALL hold the FSM state enum (BLANK, SHOW), the 16-entry glyph table, and the HEX_OFF=7'h7F and AN_OFF=8'hFF constants.
REQ-029 Sub-module seg_decode SHALL perform the combinational nibble-to-glyph conversion and be instantiated once.

Verification (PRESCALE=8, BLANK=2 unless noted)
REQ-030 Reset release, no load -> AN=FF and hex=7F for 3 full frames; frame_o pulses every 64 cycles.
REQ-031 load data_i=32'h76543210, en_i=FF mid-frame -> busy_o=1 until the boundary; next frame digit k shows glyph k in cycles 2..7 of its slot and is off in cycles 0..1.
REQ-032 Two loads in one frame (32'h11111111 then 32'hFEDCBA98) -> next frame shows FEDCBA98 only; 11111111 never appears.
REQ-033 load on the boundary cycle with en_i=8'h01, data 32'h0000000F -> the following frame shows F on digit 0 only, AN bits 7:1 stay 1, busy_o never rises.
REQ-034 rst pulsed mid-frame with a load pending -> outputs go off immediately (asynchronous); the display stays blank afterwards and busy_o=0.
REQ-035 PRESCALE=4, BLANK=3 -> exactly one SHOW cycle per slot; idx wraps 7->0 correctly.
